// File: rtl/ssid_hit_reader_pkg.sv
// Shared widths, FSM state encoding and count clamp helper for ssid_hit_reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssid_hit_reader_pkg;

    localparam int SSIDBITS  = 8;
    localparam int HITBITS   = 16;
    localparam int COUNTBITS = 4;
    localparam int MAXHITS   = 8;
    localparam int IDXBITS   = $clog2(MAXHITS);

    // Holds 0..MAXHITS, hence one bit wider than a slot index.
    typedef logic [IDXBITS:0] hitCount_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CNT_REQ  = 2'd1,
        CNT_WAIT = 2'd2,
        HIT_RD   = 2'd3
    } state_t;

    // The HCM can report more hits than there are slots; only the stored ones exist.
    function automatic hitCount_t clampCount(input logic [COUNTBITS-1:0] raw);
        if (int'(raw) > MAXHITS) begin
            return hitCount_t'(MAXHITS);
        end
        return hitCount_t'(raw);
    endfunction

endpackage

// File: rtl/ssid_hit_reader_fifo.sv
// ssid_fifo: synchronous FIFO with registered occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push while full and pop while empty are ignored.
module ssid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTRBITS = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pushEn,
    input  logic [WIDTH-1:0]   pushData,
    input  logic               popEn,
    output logic [WIDTH-1:0]   popData,
    output logic               full,
    output logic               empty,
    output logic [PTRBITS:0]   count
);

    localparam logic [PTRBITS:0] FULL_COUNT = (PTRBITS + 1)'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTRBITS-1:0] wrPtr;
    logic [PTRBITS-1:0] rdPtr;
    logic               doPush;
    logic               doPop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign doPush  = pushEn && !full;
    assign doPop   = popEn && !empty;
    assign popData = mem[rdPtr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ssid_hit_reader.sv
// Queues SSIDs, reads each hit count from the HCM, then streams that SSID's hit words.
// Latency: push to first hit_valid is 6 cycles; hits leave at one per cycle.
// Backpressure: storageReady low when the SSID queue is full; no output backpressure.
// Optional SSID_HIT_READER_STATS_EN adds stat_ssids / stat_hits counters.
module ssid_hit_reader
    import ssid_hit_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SSIDBITS-1:0]         SSID,
    input  logic                        newAddress,
    output logic                        storageReady,
    output logic                        cnt_rd_en,
    output logic [SSIDBITS-1:0]         cnt_rd_addr,
    input  logic [COUNTBITS-1:0]        cnt_rd_data,
    output logic                        hit_rd_en,
    output logic [SSIDBITS+IDXBITS-1:0] hit_rd_addr,
    input  logic [HITBITS-1:0]          hit_rd_data,
    output logic                        hit_valid,
    output logic [HITBITS-1:0]          hit_word,
    output logic [SSIDBITS-1:0]         hit_ssid,
    output logic                        hit_last,
    output logic                        empty_ssid,
    output logic                        overflow,
`ifdef SSID_HIT_READER_STATS_EN
    output logic [31:0]                 stat_ssids,
    output logic [31:0]                 stat_hits,
`endif
    output logic                        busy
);

    localparam int FPTR = $clog2(FIFO_DEPTH);
    localparam logic [FPTR:0] FIFO_FULL_COUNT = (FPTR + 1)'(FIFO_DEPTH);

    state_t               state;
    state_t               stateNext;
    logic [SSIDBITS-1:0]  curSsid;
    logic [SSIDBITS-1:0]  fifoHead;
    logic [IDXBITS-1:0]   idx;
    logic [IDXBITS-1:0]   idxNext;
    hitCount_t            nReg;
    hitCount_t            nNow;
    logic                 lastIdx;
    logic                 fifoPop;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [FPTR:0]        fifoCount;
    logic                 cntRdEn;
    logic                 hitRdEn;

    // Read-pipeline stage aligned with the one-cycle hit storage latency.
    logic                 rdVld1;
    logic                 rdLast1;
    logic [SSIDBITS-1:0]  rdSsid1;

    logic                 hitValidQ;
    logic [HITBITS-1:0]   hitWordQ;
    logic [SSIDBITS-1:0]  hitSsidQ;
    logic                 hitLastQ;
    logic                 emptySsidQ;
    logic                 overflowQ;

    ssid_fifo #(
        .WIDTH (SSIDBITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .pushEn   (newAddress),
        .pushData (SSID),
        .popEn    (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign nNow    = clampCount(cnt_rd_data);
    assign lastIdx = ({1'b0, idx} == (nReg - hitCount_t'(1)));

    // Next state, queue pop and Moore memory-read strobes.
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        fifoPop   = 1'b0;
        cntRdEn   = 1'b0;
        hitRdEn   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    stateNext = CNT_REQ;
                    fifoPop   = 1'b1;
                end
            end
            CNT_REQ: begin
                cntRdEn   = 1'b1;
                stateNext = CNT_WAIT;
            end
            CNT_WAIT: begin
                idxNext = '0;
                if (nNow != '0) begin
                    stateNext = HIT_RD;
                end else if (!fifoEmpty) begin
                    stateNext = CNT_REQ;
                    fifoPop   = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            HIT_RD: begin
                hitRdEn = 1'b1;
                idxNext = idx + 1'b1;
                if (lastIdx) begin
                    if (!fifoEmpty) begin
                        stateNext = CNT_REQ;
                        fifoPop   = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM state, slot index, current SSID and its clamped hit count.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            curSsid <= '0;
            nReg    <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            if (fifoPop) begin
                curSsid <= fifoHead;
            end
            if (state == CNT_WAIT) begin
                nReg <= nNow;
            end
        end
    end

    // Delay read strobe, owner SSID and last flag to meet returning hit data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdVld1  <= 1'b0;
            rdLast1 <= 1'b0;
            rdSsid1 <= '0;
        end else begin
            rdVld1  <= hitRdEn;
            rdLast1 <= hitRdEn && lastIdx;
            rdSsid1 <= curSsid;
        end
    end

    // Registered output stage plus empty-SSID pulse and sticky drop flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            hitValidQ  <= 1'b0;
            hitWordQ   <= '0;
            hitSsidQ   <= '0;
            hitLastQ   <= 1'b0;
            emptySsidQ <= 1'b0;
            overflowQ  <= 1'b0;
        end else begin
            hitValidQ  <= rdVld1;
            hitLastQ   <= rdLast1;
            if (rdVld1) begin
                hitWordQ <= hit_rd_data;
                hitSsidQ <= rdSsid1;
            end
            emptySsidQ <= (state == CNT_WAIT) && (nNow == '0);
            // A push into a full queue is lost even if a pop frees a slot this cycle.
            overflowQ  <= overflowQ || (newAddress && fifoFull);
        end
    end

`ifdef SSID_HIT_READER_STATS_EN
    // Wrapping counters of SSIDs finished with the count lookup and hit words emitted.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_ssids <= '0;
            stat_hits  <= '0;
        end else begin
            if (state == CNT_WAIT) begin
                stat_ssids <= stat_ssids + 32'd1;
            end
            if (hitValidQ) begin
                stat_hits <= stat_hits + 32'd1;
            end
        end
    end
`endif

    assign storageReady = (fifoCount != FIFO_FULL_COUNT);
    assign cnt_rd_en    = cntRdEn;
    assign cnt_rd_addr  = curSsid;
    assign hit_rd_en    = hitRdEn;
    assign hit_rd_addr  = {curSsid, idx};
    assign hit_valid    = hitValidQ;
    assign hit_word     = hitWordQ;
    assign hit_ssid     = hitSsidQ;
    assign hit_last     = hitLastQ;
    assign empty_ssid   = emptySsidQ;
    assign overflow     = overflowQ;
    assign busy         = (state != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_ssid_hit_reader.sv
// Self-checking bench for ssid_hit_reader with behavioural HCM and hit storage.
// Latency: checks cycle positions relative to the push cycle.
// Backpressure: exercises queue fill, drop and sticky overflow.
module tb_ssid_hit_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  SSID;
    logic        newAddress;
    logic        storageReady;
    logic        cnt_rd_en;
    logic [7:0]  cnt_rd_addr;
    logic [3:0]  cnt_rd_data;
    logic        hit_rd_en;
    logic [10:0] hit_rd_addr;
    logic [15:0] hit_rd_data;
    logic        hit_valid;
    logic [15:0] hit_word;
    logic [7:0]  hit_ssid;
    logic        hit_last;
    logic        empty_ssid;
    logic        overflow;
    logic        busy;
`ifdef SSID_HIT_READER_STATS_EN
    logic [31:0] stat_ssids;
    logic [31:0] stat_hits;
`endif

    typedef struct packed {
        logic [7:0]  ssid;
        logic [15:0] word;
        logic        last;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monExp;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] hcm [256];

    always #5 clock = ~clock;

    ssid_hit_reader dut (
        .clock        (clock),
        .reset        (reset),
        .SSID         (SSID),
        .newAddress   (newAddress),
        .storageReady (storageReady),
        .cnt_rd_en    (cnt_rd_en),
        .cnt_rd_addr  (cnt_rd_addr),
        .cnt_rd_data  (cnt_rd_data),
        .hit_rd_en    (hit_rd_en),
        .hit_rd_addr  (hit_rd_addr),
        .hit_rd_data  (hit_rd_data),
        .hit_valid    (hit_valid),
        .hit_word     (hit_word),
        .hit_ssid     (hit_ssid),
        .hit_last     (hit_last),
        .empty_ssid   (empty_ssid),
        .overflow     (overflow),
`ifdef SSID_HIT_READER_STATS_EN
        .stat_ssids   (stat_ssids),
        .stat_hits    (stat_hits),
`endif
        .busy         (busy)
    );

    // Hit word pattern: SSID 0x37 yields 0xA000 + idx; other SSIDs differ in the top byte.
    function automatic logic [15:0] hitWord(input logic [7:0] s, input logic [2:0] i);
        logic [7:0] hi;
        hi = s ^ 8'h37 ^ 8'hA0;
        return {hi, 5'b00000, i};
    endfunction

    // One-cycle-latency memories.
    always @(posedge clock) begin
        if (cnt_rd_en) cnt_rd_data <= hcm[cnt_rd_addr];
        if (hit_rd_en) hit_rd_data <= hitWord(hit_rd_addr[10:3], hit_rd_addr[2:0]);
    end

    // Scoreboard: every emitted hit must match the oldest expected one.
    always @(negedge clock) begin
        if (hit_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL stray_hit: got ssid %h word %h last %b, want no hit", hit_ssid, hit_word, hit_last);
            end else begin
                monExp = expQ.pop_front();
                if ({hit_ssid, hit_word, hit_last} !== {monExp.ssid, monExp.word, monExp.last}) begin
                    errors++;
                    $display("FAIL hit_data: got ssid %h word %h last %b, want ssid %h word %h last %b",
                             hit_ssid, hit_word, hit_last, monExp.ssid, monExp.word, monExp.last);
                end
            end
        end
    end

    task automatic expectSsid(input logic [7:0] s);
        int   n;
        exp_t e;
        n = (hcm[s] > 4'd8) ? 8 : int'(hcm[s]);
        for (int i = 0; i < n; i++) begin
            e.ssid = s;
            e.word = hitWord(s, 3'(i));
            e.last = (i == n - 1);
            expQ.push_back(e);
        end
    endtask

    // Drives the strobe for one cycle; returns at the negedge of cycle 1.
    task automatic pushOne(input logic [7:0] s);
        SSID       = s;
        newAddress = 1'b1;
        expectSsid(s);
        @(negedge clock);
        newAddress = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int k;
        k = 0;
        while ((busy || expQ.size() != 0) && k < budget) begin
            @(negedge clock);
            k++;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: busy %b pending %0d, want 0 0", name, busy, expQ.size());
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        newAddress = 1'b0;
        SSID       = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({cnt_rd_en, hit_rd_en, hit_valid, hit_last, empty_ssid, overflow, busy, storageReady} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 00000001",
                     {cnt_rd_en, hit_rd_en, hit_valid, hit_last, empty_ssid, overflow, busy, storageReady});
        end
        checks++;
        if ({cnt_rd_addr, hit_rd_addr, hit_word, hit_ssid} !== 43'd0) begin
            errors++;
            $display("FAIL reset_buses: got %h %h %h %h, want all 0", cnt_rd_addr, hit_rd_addr, hit_word, hit_ssid);
        end
    endtask

    task automatic test_basic;
        pushOne(8'h37);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_c1: got %b, want 1", busy);
        end
        @(negedge clock);
        checks++;
        if (cnt_rd_en !== 1'b1 || cnt_rd_addr !== 8'h37) begin
            errors++;
            $display("FAIL basic_cnt_rd_c2: got en %b addr %h, want 1 37", cnt_rd_en, cnt_rd_addr);
        end
        @(negedge clock);
        checks++;
        if (cnt_rd_en !== 1'b0 || hit_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait_c3: got cnt_en %b hit_en %b, want 0 0", cnt_rd_en, hit_rd_en);
        end
        @(negedge clock);
        checks++;
        if (hit_rd_en !== 1'b1 || hit_rd_addr !== {8'h37, 3'd0}) begin
            errors++;
            $display("FAIL basic_hit_rd_c4: got en %b addr %h, want 1 1b8", hit_rd_en, hit_rd_addr);
        end
        for (int k = 5; k <= 9; k++) begin
            @(negedge clock);
            checks++;
            if (hit_valid !== (k >= 6 && k <= 8) || hit_last !== (k == 8)) begin
                errors++;
                $display("FAIL basic_timing_c%0d: got valid %b last %b, want %b %b",
                         k, hit_valid, hit_last, (k >= 6 && k <= 8), (k == 8));
            end
        end
        waitDrain("basic", 40);
`ifdef SSID_HIT_READER_STATS_EN
        checks++;
        if (stat_ssids !== 32'd1 || stat_hits !== 32'd3) begin
            errors++;
            $display("FAIL basic_stats: got %0d %0d, want 1 3", stat_ssids, stat_hits);
        end
`endif
    endtask

    task automatic test_empty;
        pushOne(8'h12);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            checks++;
            if (empty_ssid !== (k == 4)) begin
                errors++;
                $display("FAIL empty_pulse_c%0d: got %b, want %b", k, empty_ssid, (k == 4));
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_idle: busy %b, want 0", busy);
        end
        waitDrain("empty", 20);
    endtask

    task automatic test_clamp;
        int seen;
        seen = 0;
        pushOne(8'h5A);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (hit_valid) seen++;
        end
        checks++;
        if (seen != 8) begin
            errors++;
            $display("FAIL clamp_count: got %0d words, want 8", seen);
        end
        waitDrain("clamp", 20);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                checks++;
                if (storageReady !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_ready_c4: got %b, want 1", storageReady);
                end
            end
            if (i == 5) begin
                checks++;
                if (storageReady !== 1'b0 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full_c5: got ready %b overflow %b, want 0 0", storageReady, overflow);
                end
            end
            SSID       = 8'h40 + 8'(i);
            newAddress = 1'b1;
            if (i < 5) expectSsid(8'h40 + 8'(i));
            @(negedge clock);
        end
        newAddress = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b, want 1", overflow);
        end
        waitDrain("overflow", 200);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, want 1", overflow);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vMask, lMask, cMask, hMask;
        vMask = '0;
        lMask = '0;
        cMask = '0;
        hMask = '0;
        SSID       = 8'h21;
        newAddress = 1'b1;
        expectSsid(8'h21);
        @(negedge clock);
        SSID = 8'h22;
        expectSsid(8'h22);
        @(negedge clock);
        newAddress = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            vMask[k] = hit_valid;
            lMask[k] = hit_last;
            cMask[k] = cnt_rd_en;
            hMask[k] = hit_rd_en;
            @(negedge clock);
        end
        checks++;
        if (vMask !== 16'h04C0) begin
            errors++;
            $display("FAIL b2b_valid: got %h, want 04c0", vMask);
        end
        checks++;
        if (lMask !== 16'h0480) begin
            errors++;
            $display("FAIL b2b_last: got %h, want 0480", lMask);
        end
        checks++;
        if (cMask !== 16'h0044 || hMask !== 16'h0130) begin
            errors++;
            $display("FAIL b2b_reads: got cnt %h hit %h, want 0044 0130", cMask, hMask);
        end
        waitDrain("b2b", 30);
    endtask

    task automatic test_reset_mid;
        SSID       = 8'h66;
        newAddress = 1'b1;
        expectSsid(8'h66);
        @(negedge clock);
        SSID = 8'h67;
        expectSsid(8'h67);
        @(negedge clock);
        newAddress = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (hit_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_hit_rd: got %b, want 1", hit_rd_en);
        end
        reset = 1'b1;
        expQ.delete();
        @(negedge clock);
        checks++;
        if ({cnt_rd_en, hit_rd_en, hit_valid, hit_last, empty_ssid, overflow, busy, storageReady} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL rstmid_flags: got %b, want 00000001",
                     {cnt_rd_en, hit_rd_en, hit_valid, hit_last, empty_ssid, overflow, busy, storageReady});
        end
        checks++;
        if ({cnt_rd_addr, hit_rd_addr, hit_word, hit_ssid} !== 43'd0) begin
            errors++;
            $display("FAIL rstmid_buses: got %h %h %h %h, want all 0", cnt_rd_addr, hit_rd_addr, hit_word, hit_ssid);
        end
`ifdef SSID_HIT_READER_STATS_EN
        checks++;
        if (stat_ssids !== 32'd0 || stat_hits !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_stats: got %0d %0d, want 0 0", stat_ssids, stat_hits);
        end
`endif
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_hit: got %b, want 0", hit_valid);
        end
        repeat (15) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_fifo_empty: busy %b, want 0", busy);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) hcm[a] = 4'd0;
        hcm[8'h37] = 4'd3;
        hcm[8'h12] = 4'd0;
        hcm[8'h5A] = 4'd15;
        hcm[8'h21] = 4'd2;
        hcm[8'h22] = 4'd1;
        hcm[8'h66] = 4'd8;
        hcm[8'h67] = 4'd8;
        for (int a = 8'h40; a <= 8'h45; a++) hcm[a] = 4'd8;

        test_reset;
        test_basic;
        test_empty;
        test_clamp;
        test_overflow;
        test_back_to_back;
        test_reset_mid;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
